// File: rtl/sync_fifo_rd_packer_if.sv
// Bundles the FIFO read port, flush control and packed output stream of the read packer.
// The master modport is the packer side; the slave modport is the FIFO/downstream side.
interface sync_fifo_rd_packer_if #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
);
    logic                   fifo_empty;
    logic [WIDTH-1:0]       fifo_rd_data;
    logic                   fifo_rd_en;
    logic                   flush;
    logic                   flush_busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [RATIO*WIDTH-1:0] out_data;
    logic [RATIO-1:0]       out_keep;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        input  flush,
        output flush_busy,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_keep
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        output flush,
        input  flush_busy,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_keep
    );
endinterface

// File: rtl/sync_fifo_rd_packer.sv
// Pops words from a show-ahead FIFO and packs RATIO of them into one wide beat,
// with a flush path that forces out a partially filled beat carrying a keep mask.
module sync_fifo_rd_packer #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
) (
    input  logic                  clock,
    input  logic                  rstn,
    sync_fifo_rd_packer_if.master bus
);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        ACCUM,
        FLUSH
    } state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_cnt;
    logic [RATIO-1:0][WIDTH-1:0] r_acc;
    logic [RATIO-1:0][WIDTH-1:0] r_outData;
    logic [RATIO-1:0]            r_outKeep;
    logic                        r_outValid;
    logic                        r_flushBusy;

    logic [RATIO-1:0][WIDTH-1:0] w_fullBeat;
    logic [RATIO-1:0]            w_partKeep;
    logic                        w_slotFree;
    logic                        w_lastLane;
    logic                        w_pop;

    // The last lane may only be popped when the output slot can take the completed beat.
    assign w_slotFree = !r_outValid || bus.out_ready;
    assign w_lastLane = (r_cnt == CW'(RATIO-1));
    assign w_pop      = rstn && (r_state == ACCUM) && !bus.fifo_empty
                        && (!w_lastLane || w_slotFree);

    always_comb begin
        w_fullBeat            = r_acc;
        w_fullBeat[RATIO-1]   = bus.fifo_rd_data;
        w_partKeep            = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_partKeep[i] = (i < int'(r_cnt));
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_outData   <= '0;
            r_outKeep   <= '0;
            r_outValid  <= 1'b0;
            r_flushBusy <= 1'b0;
        end else begin
            if (r_outValid && bus.out_ready) begin
                r_outValid <= 1'b0;
            end
            case (r_state)
                ACCUM: begin
                    if (w_pop) begin
                        if (w_lastLane) begin
                            r_outData  <= w_fullBeat;
                            r_outKeep  <= '1;
                            r_outValid <= 1'b1;
                            r_cnt      <= '0;
                            r_acc      <= '0;
                        end else begin
                            r_acc[r_cnt] <= bus.fifo_rd_data;
                            r_cnt        <= r_cnt + CW'(1);
                        end
                    end
                    if (bus.flush) begin
                        r_state     <= FLUSH;
                        r_flushBusy <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Unfilled lanes are already zero because the accumulator clears on every emit.
                    if (r_cnt == '0) begin
                        r_flushBusy <= 1'b0;
                        r_state     <= ACCUM;
                    end else if (w_slotFree) begin
                        r_outData   <= r_acc;
                        r_outKeep   <= w_partKeep;
                        r_outValid  <= 1'b1;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_flushBusy <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign bus.fifo_rd_en = w_pop;
    assign bus.flush_busy = r_flushBusy;
    assign bus.out_valid  = r_outValid;
    assign bus.out_data   = r_outData;
    assign bus.out_keep   = r_outKeep;
endmodule
